bcd_mod_counter: RTL and testbench
==================================

// Module: bcd_mod_counter
// PURPOSE
//   Parametrised two-digit BCD modulo counter for the clock datapath; one
//   instance per time field (seconds/minutes MODULUS=60, hours MODULUS=24).
//   Counts up or down on a clock-enable tick, supports synchronous preset for
//   time setting, and emits a one-cycle carry/borrow pulse that drives the
//   enable of the next field.
// PARAMETERS
//   MODULUS   60  count range 0..MODULUS-1; legal 2..99, else elaboration error
//   INIT_VAL  0   value loaded on reset, binary, must be < MODULUS
// PORTS
//   clk        in   1  single clock; all state changes on posedge
//   reset      in   1  synchronous, active-low reset
//   en         in   1  count tick; one step per cycle when high
//   up_dn      in   1  1 = count up, 0 = count down; sampled with en
//   load       in   1  synchronous preset strobe
//   load_tens  in   4  preset tens digit, BCD
//   load_ones  in   4  preset ones digit, BCD
//   tens       out  4  tens digit, BCD, registered
//   ones       out  4  ones digit, BCD, registered
//   carry      out  1  registered one-cycle wrap pulse (carry or borrow)
// BEHAVIOUR
// - Priority per cycle: reset low > load > en > hold.
// - Reset (reset==0 at posedge): {tens,ones} <= BCD(INIT_VAL), carry <= 0.
//   Reset mid-count or mid-load discards the pending operation.
// - Load: {tens,ones} <= {load_tens,load_ones} if both digits <= 9 and
//   value < MODULUS; otherwise {tens,ones} <= 00. carry <= 0. en ignored.
// - Up (en=1, up_dn=1): ones 9 -> 0 with tens+1; value MODULUS-1 -> 00 and
//   carry <= 1 in the same edge (carry high while outputs show 00).
// - Down (en=1, up_dn=0): ones 0 -> 9 with tens-1; value 00 -> MODULUS-1
//   and carry <= 1 (borrow).
// - carry is high exactly one cycle per wrap; cleared on any edge where no
//   wrap occurs, including en=0 cycles. Back-to-back wraps (MODULUS=2 with
//   en held) give carry high on consecutive cycles.
// - en=0, load=0: outputs hold; carry <= 0.
// - Latency: one clk from en/load to updated outputs; no combinational path
//   from inputs to outputs.
// - Arithmetic per digit in 4-bit BCD; outputs never leave 0..MODULUS-1
//   after the first clock edge following reset.
// CONFIGURATION
// - Macro BCD_CNT_MATCH_EN (alarm compare):
//   defined: extra ports match_tens in 4, match_ones in 4, match out 1.
//     match is registered: high in every cycle whose {tens,ones} equals the
//     match value sampled the previous cycle; reset value 0; no effect on
//     counting or carry.
//   undefined: ports absent, no compare logic; counter behaviour identical.
// TESTING
// 1. Reset low one edge, INIT_VAL=0 -> tens=0, ones=0, carry=0.
// 2. MODULUS=60, load 58, en=1 up 3 ticks -> 59, 00 with carry=1, 01 with
//    carry=0.
// 3. MODULUS=60, load 01, en=1 down 2 ticks -> 00 (carry=0), 59 (carry=1).
// 4. MODULUS=24, count up from 22 -> 23, 00 with carry=1; 09 -> 10 no carry.
// 5. load=1 and en=1 same cycle with 45 -> 45 loaded, no step, carry=0;
//    load 7A or 61 (MODULUS=60) -> 00.
// 6. reset low while en=1 at 59 -> 00 next edge, carry=0 (no wrap pulse);
//    with BCD_CNT_MATCH_EN, match 30 -> match high only while count shows 30.

Source files
------------

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter with up/down count, synchronous preset and a
// one-cycle wrap pulse. Optional alarm compare is enabled by BCD_CNT_MATCH_EN.
module bcd_mod_counter #(
    parameter int MODULUS  = 60,
    parameter int INIT_VAL = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       up_dn,
    input  logic       load,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_ones,
`ifdef BCD_CNT_MATCH_EN
    input  logic [3:0] match_tens,
    input  logic [3:0] match_ones,
    output logic       match,
`endif
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       carry
);

    if (MODULUS < 2 || MODULUS > 99) begin : g_bad_modulus
        $error("bcd_mod_counter: MODULUS %0d outside 2..99", MODULUS);
    end
    if (INIT_VAL < 0 || INIT_VAL >= MODULUS) begin : g_bad_init
        $error("bcd_mod_counter: INIT_VAL %0d not below MODULUS %0d", INIT_VAL, MODULUS);
    end

    localparam logic [3:0] MAX_T  = 4'((MODULUS - 1) / 10);
    localparam logic [3:0] MAX_O  = 4'((MODULUS - 1) % 10);
    localparam logic [3:0] INIT_T = 4'(INIT_VAL / 10);
    localparam logic [3:0] INIT_O = 4'(INIT_VAL % 10);

    logic [7:0] load_bin;
    logic       load_ok;
    logic [3:0] tens_nxt;
    logic [3:0] ones_nxt;
    logic       carry_nxt;

    assign load_bin = 8'(load_tens) * 8'd10 + 8'(load_ones);
    assign load_ok  = (load_tens <= 4'd9) && (load_ones <= 4'd9)
                      && (load_bin < 8'(MODULUS));

    always_comb begin
        tens_nxt  = tens;
        ones_nxt  = ones;
        carry_nxt = 1'b0;
        if (load) begin
            if (load_ok) begin
                tens_nxt = load_tens;
                ones_nxt = load_ones;
            end else begin
                tens_nxt = '0;
                ones_nxt = '0;
            end
        end else if (en) begin
            if (up_dn) begin
                if (tens == MAX_T && ones == MAX_O) begin
                    tens_nxt  = '0;
                    ones_nxt  = '0;
                    carry_nxt = 1'b1;
                end else if (ones == 4'd9) begin
                    ones_nxt = '0;
                    tens_nxt = tens + 4'd1;
                end else begin
                    ones_nxt = ones + 4'd1;
                end
            end else begin
                // Borrow out of 00 lands on MODULUS-1, not 99.
                if (tens == '0 && ones == '0) begin
                    tens_nxt  = MAX_T;
                    ones_nxt  = MAX_O;
                    carry_nxt = 1'b1;
                end else if (ones == '0) begin
                    ones_nxt = 4'd9;
                    tens_nxt = tens - 4'd1;
                end else begin
                    ones_nxt = ones - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            tens  <= INIT_T;
            ones  <= INIT_O;
            carry <= 1'b0;
        end else begin
            tens  <= tens_nxt;
            ones  <= ones_nxt;
            carry <= carry_nxt;
        end
    end

`ifdef BCD_CNT_MATCH_EN
    // Compared against the next count so match lines up with the displayed value.
    always_ff @(posedge clk) begin
        if (!reset) begin
            match <= 1'b0;
        end else begin
            match <= ({tens_nxt, ones_nxt} == {match_tens, match_ones});
        end
    end
`endif

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Directed self-checking bench for bcd_mod_counter: MODULUS 60, 24 (INIT 12)
// and 2 instances share stimulus; each scenario task checks its own results.
module tb_bcd_mod_counter;

    logic       clk = 1'b0;
    logic       reset, en, up_dn, load;
    logic [3:0] load_tens, load_ones;
    logic [3:0] t60, o60, t24, o24, t2, o2;
    logic       c60, c24, c2;
    int         asserts = 0;
    int         failures = 0;
`ifdef BCD_CNT_MATCH_EN
    logic [3:0] match_tens, match_ones;
    logic       m60, m24, m2;
`endif

    always #5 clk = ~clk;

    bcd_mod_counter #(.MODULUS(60), .INIT_VAL(0)) dut60 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_tens(load_tens), .load_ones(load_ones),
`ifdef BCD_CNT_MATCH_EN
        .match_tens(match_tens), .match_ones(match_ones), .match(m60),
`endif
        .tens(t60), .ones(o60), .carry(c60));

    bcd_mod_counter #(.MODULUS(24), .INIT_VAL(12)) dut24 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_tens(load_tens), .load_ones(load_ones),
`ifdef BCD_CNT_MATCH_EN
        .match_tens(match_tens), .match_ones(match_ones), .match(m24),
`endif
        .tens(t24), .ones(o24), .carry(c24));

    bcd_mod_counter #(.MODULUS(2), .INIT_VAL(0)) dut2 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_tens(load_tens), .load_ones(load_ones),
`ifdef BCD_CNT_MATCH_EN
        .match_tens(match_tens), .match_ones(match_ones), .match(m2),
`endif
        .tens(t2), .ones(o2), .carry(c2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] t, input logic [3:0] o);
        load = 1'b1; en = 1'b0; load_tens = t; load_ones = o;
        tick();
        load = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        asserts++;
        if ({t60, o60, c60} !== {4'd0, 4'd0, 1'b0}) begin
            failures++;
            $display("FAIL reset60 got %h%h c=%b want 00 c=0", t60, o60, c60);
        end
        asserts++;
        if ({t24, o24, c24} !== {4'd1, 4'd2, 1'b0}) begin
            failures++;
            $display("FAIL reset24_init got %h%h c=%b want 12 c=0", t24, o24, c24);
        end
        asserts++;
        if ({t2, o2, c2} !== {4'd0, 4'd0, 1'b0}) begin
            failures++;
            $display("FAIL reset2 got %h%h c=%b want 00 c=0", t2, o2, c2);
        end
        reset = 1'b1;
    endtask

    task automatic test_up_wrap();
        logic [8:0] exp [4] = '{{4'd5, 4'd9, 1'b0}, {4'd0, 4'd0, 1'b1},
                                {4'd0, 4'd1, 1'b0}, {4'd0, 4'd1, 1'b0}};
        do_load(4'd5, 4'd8);
        asserts++;
        if ({t60, o60, c60} !== {4'd5, 4'd8, 1'b0}) begin
            failures++;
            $display("FAIL up_load58 got %h%h c=%b want 58 c=0", t60, o60, c60);
        end
        en = 1'b1; up_dn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) en = 1'b0;
            tick();
            asserts++;
            if ({t60, o60, c60} !== exp[i]) begin
                failures++;
                $display("FAIL up_step%0d got %h%h c=%b want %h%h c=%b", i, t60, o60, c60,
                         exp[i][8:5], exp[i][4:1], exp[i][0]);
            end
        end
    endtask

    task automatic test_down_borrow();
        logic [8:0] exp [3] = '{{4'd0, 4'd0, 1'b0}, {4'd5, 4'd9, 1'b1}, {4'd5, 4'd8, 1'b0}};
        do_load(4'd0, 4'd1);
        en = 1'b1; up_dn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            asserts++;
            if ({t60, o60, c60} !== exp[i]) begin
                failures++;
                $display("FAIL down_step%0d got %h%h c=%b want %h%h c=%b", i, t60, o60, c60,
                         exp[i][8:5], exp[i][4:1], exp[i][0]);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_digit_roll();
        do_load(4'd3, 4'd9);
        en = 1'b1; up_dn = 1'b1;
        tick();
        asserts++;
        if ({t60, o60, c60} !== {4'd4, 4'd0, 1'b0}) begin
            failures++;
            $display("FAIL roll_39up got %h%h c=%b want 40 c=0", t60, o60, c60);
        end
        up_dn = 1'b0;
        tick();
        asserts++;
        if ({t60, o60, c60} !== {4'd3, 4'd9, 1'b0}) begin
            failures++;
            $display("FAIL roll_40dn got %h%h c=%b want 39 c=0", t60, o60, c60);
        end
        en = 1'b0;
    endtask

    task automatic test_mod24();
        do_load(4'd2, 4'd2);
        en = 1'b1; up_dn = 1'b1;
        tick();
        asserts++;
        if ({t24, o24, c24} !== {4'd2, 4'd3, 1'b0}) begin
            failures++;
            $display("FAIL m24_23 got %h%h c=%b want 23 c=0", t24, o24, c24);
        end
        tick();
        asserts++;
        if ({t24, o24, c24} !== {4'd0, 4'd0, 1'b1}) begin
            failures++;
            $display("FAIL m24_wrap got %h%h c=%b want 00 c=1", t24, o24, c24);
        end
        do_load(4'd0, 4'd9);
        en = 1'b1; up_dn = 1'b1;
        tick();
        asserts++;
        if ({t24, o24, c24} !== {4'd1, 4'd0, 1'b0}) begin
            failures++;
            $display("FAIL m24_09up got %h%h c=%b want 10 c=0", t24, o24, c24);
        end
        do_load(4'd0, 4'd0);
        en = 1'b1; up_dn = 1'b0;
        tick();
        asserts++;
        if ({t24, o24, c24} !== {4'd2, 4'd3, 1'b1}) begin
            failures++;
            $display("FAIL m24_borrow got %h%h c=%b want 23 c=1", t24, o24, c24);
        end
        en = 1'b0;
    endtask

    task automatic test_load();
        do_load(4'd5, 4'd9);
        asserts++;
        if ({t60, o60, c60} !== {4'd5, 4'd9, 1'b0}) begin
            failures++;
            $display("FAIL load59 got %h%h c=%b want 59 c=0", t60, o60, c60);
        end
        // load and en together at 59: load must win, no wrap pulse
        load = 1'b1; en = 1'b1; up_dn = 1'b1; load_tens = 4'd4; load_ones = 4'd5;
        tick();
        asserts++;
        if ({t60, o60, c60} !== {4'd4, 4'd5, 1'b0}) begin
            failures++;
            $display("FAIL load_pri45 got %h%h c=%b want 45 c=0", t60, o60, c60);
        end
        asserts++;
        if ({t24, o24, c24} !== {4'd0, 4'd0, 1'b0}) begin
            failures++;
            $display("FAIL load24_45 got %h%h c=%b want 00 c=0", t24, o24, c24);
        end
        load_tens = 4'd7; load_ones = 4'hA;
        tick();
        asserts++;
        if ({t60, o60, c60} !== {4'd0, 4'd0, 1'b0}) begin
            failures++;
            $display("FAIL load7A got %h%h c=%b want 00 c=0", t60, o60, c60);
        end
        load_tens = 4'd4; load_ones = 4'd5;
        tick();
        load_tens = 4'd6; load_ones = 4'd1;
        tick();
        asserts++;
        if ({t60, o60, c60} !== {4'd0, 4'd0, 1'b0}) begin
            failures++;
            $display("FAIL load61 got %h%h c=%b want 00 c=0", t60, o60, c60);
        end
        load = 1'b0; en = 1'b0;
    endtask

    task automatic test_reset_midcount();
        do_load(4'd5, 4'd9);
        en = 1'b1; up_dn = 1'b1; reset = 1'b0;
        tick();
        asserts++;
        if ({t60, o60, c60} !== {4'd0, 4'd0, 1'b0}) begin
            failures++;
            $display("FAIL rst_count60 got %h%h c=%b want 00 c=0", t60, o60, c60);
        end
        asserts++;
        if ({t24, o24, c24} !== {4'd1, 4'd2, 1'b0}) begin
            failures++;
            $display("FAIL rst_count24 got %h%h c=%b want 12 c=0", t24, o24, c24);
        end
        en = 1'b0; reset = 1'b1;
        do_load(4'd3, 4'd3);
        load = 1'b1; load_tens = 4'd4; load_ones = 4'd5; reset = 1'b0;
        tick();
        asserts++;
        if ({t60, o60, c60} !== {4'd0, 4'd0, 1'b0}) begin
            failures++;
            $display("FAIL rst_load60 got %h%h c=%b want 00 c=0", t60, o60, c60);
        end
        load = 1'b0; reset = 1'b1;
    endtask

    task automatic test_back_to_back();
        // dut2 from 0: down, up, down, up each wraps; then up held 0->1 no wrap
        logic [4:0] dirs = 5'b11010;
        logic [8:0] exp [5] = '{{4'd0, 4'd1, 1'b1}, {4'd0, 4'd0, 1'b1}, {4'd0, 4'd1, 1'b1},
                                {4'd0, 4'd0, 1'b1}, {4'd0, 4'd1, 1'b0}};
        reset = 1'b0;
        tick();
        reset = 1'b1; en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            up_dn = dirs[i];
            tick();
            asserts++;
            if ({t2, o2, c2} !== exp[i]) begin
                failures++;
                $display("FAIL b2b_step%0d got %h%h c=%b want %h%h c=%b", i, t2, o2, c2,
                         exp[i][8:5], exp[i][4:1], exp[i][0]);
            end
        end
        en = 1'b0;
        tick();
        asserts++;
        if ({t2, o2, c2} !== {4'd0, 4'd1, 1'b0}) begin
            failures++;
            $display("FAIL b2b_hold got %h%h c=%b want 01 c=0", t2, o2, c2);
        end
    endtask

`ifdef BCD_CNT_MATCH_EN
    task automatic test_match();
        match_tens = 4'd3; match_ones = 4'd0;
        do_load(4'd2, 4'd9);
        en = 1'b1; up_dn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            asserts++;
            if (m60 !== (i == 0)) begin
                failures++;
                $display("FAIL match_step%0d got %b want %b (count %h%h)", i, m60, (i == 0),
                         t60, o60);
            end
        end
        en = 1'b0;
    endtask
`endif

    initial begin
        reset = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0;
        load_tens = '0; load_ones = '0;
`ifdef BCD_CNT_MATCH_EN
        match_tens = 4'hF; match_ones = 4'hF;
`endif
        test_reset();
        test_up_wrap();
        test_down_borrow();
        test_digit_roll();
        test_mod24();
        test_load();
        test_reset_midcount();
        test_back_to_back();
`ifdef BCD_CNT_MATCH_EN
        test_match();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
